sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Request sequencer directly upstream of the 16-bank SRAM address decoder.
- Accepts read/write burst requests over a valid/ready handshake.
- Drives the decoder's 18-bit address and active-low WEN/CEN, one SRAM beat per cycle.
- Returns read data from the downstream bank read mux on a registered rd_valid stream.

Parameters:
- AW, 18, address width; bits [17:14] select the bank, [13:0] are the word within the bank.
- DW, 32, data width.
- LW, 4, burst-length field width; a request issues req_len+1 beats.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = write burst, 0 = read burst.
- req_addr  input  AW  start word address.
- req_len  input  LW  beats minus one.
- wr_valid  input  1  write beat data present.
- wr_ready  output  1  write beat accepted when high together with wr_valid.
- wr_data  input  DW  write beat data.
- rd_valid  output  1  read beat valid; no backpressure.
- rd_data  output  DW  read beat data.
- rd_last  output  1  final beat of the read burst.
- busy  output  1  a burst is active or read data is still in flight.
- A_out  output  AW  SRAM address to the decoder (registered).
- WEN_out  output  1  active-low write enable to the decoder (registered).
- CEN_out  output  1  active-low chip enable to the decoder (registered).
- D_out  output  DW  SRAM write data (registered).
- Q_in  input  DW  read data from the bank mux; valid in the cycle after a read beat's CEN_out-low cycle.

Behaviour:
- Reset values:
  - State IDLE; A_out=0; D_out=0; CEN_out=1; WEN_out=1.
  - rd_valid=0; rd_last=0; rd_data=0; in-flight pipeline cleared; beat counter=0.
  - Reset mid-burst abandons the burst. No rd_valid is produced for beats issued before reset.
- FSM states: IDLE, RD, WR, DRAIN.
  - IDLE: req_ready=1 when the read pipeline is empty.
    - On req_valid&&req_ready, latch addr, len and write, then go to WR or RD.
    - CEN_out=1 and WEN_out=1 every IDLE cycle.
  - RD: one beat per cycle, no stalls.
    - Register CEN_out=0, WEN_out=1, A_out=addr.
    - addr increments and the beat count increments.
    - After beat len+1 is issued, go to DRAIN.
  - WR: wr_ready=1.
    - On wr_valid, register CEN_out=0, WEN_out=0, A_out=addr, D_out=wr_data; addr increments.
    - With wr_valid low, register CEN_out=1 and WEN_out=1. A_out and D_out hold.
    - After beat len+1 is accepted, go to IDLE.
    - wr_ready=0 outside WR.
  - DRAIN: CEN_out=1; stay until the read pipeline is empty, then go to IDLE.
- Read latency:
  - Accept edge E.
  - CEN_out low in cycle E+1.
  - Q_in valid in cycle E+2, registered into rd_data.
  - rd_valid=1 in cycle E+3.
  - rd_valid/rd_last are tracked by a 2-stage valid/last shift pipeline; rd_last marks beat len+1.
- Address arithmetic:
  - Increment is modulo 2^AW: 0x3FFFF+1 = 0x00000.
  - Bank boundaries are crossed naturally, e.g. 0x03FFF -> 0x04000 moves from bank 0 to bank 1.
- Burst length: req_len=0 gives 1 beat; req_len=15 gives 16 beats.
- Handshake rules:
  - req_ready=0 in RD, WR and DRAIN.
  - A request held during a busy period is accepted in the first IDLE cycle with an empty pipeline.
  - After a write burst, req_ready=1 in the cycle after the last beat's acceptance edge.
- busy = (state!=IDLE) | pipeline-nonempty.
- Write data is never issued to the SRAM without wr_valid.

Test Plan:
- Reset:
  - Assert rst for 2 cycles mid-RD burst.
  - Next cycle: CEN_out=1, WEN_out=1, A_out=0, rd_valid=0, req_ready=1, and no further rd_valid.
- Bank-crossing read:
  - Read addr=0x03FFF, len=1, Q_in model returns the address.
  - A_out=0x03FFF then 0x04000, with CEN_out=0 for exactly 2 cycles.
  - rd_valid at E+3 and E+4 with data 0x03FFF then 0x04000; rd_last only on the second beat.
- Write with gaps:
  - Write addr=0x10, len=2, wr_valid pattern 1,0,1,1, data AA, BB, CC.
  - CEN_out/WEN_out low in 3 cycles only, at A_out 0x10, 0x11, 0x12 with D_out AA, BB, CC.
  - Idle-gap cycle has CEN_out=1; req_ready returns after the last beat.
- Wrap:
  - Read addr=0x3FFFE, len=3.
  - A_out sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; 4 rd_valid beats, last with rd_last.
- Back-to-back:
  - req_valid held high with a read len=0 then a write len=0.
  - Second request is accepted only after rd_valid/rd_last of the first.
  - busy stays high throughout; no CEN_out-low overlap between the two.
- Max burst:
  - Read len=15 at 0x0.
  - 16 consecutive CEN_out-low cycles, then 16 consecutive rd_valid cycles; rd_last on the 16th only.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Burst request sequencer in front of the 16-bank SRAM address decoder.
// Issues one registered SRAM beat per cycle and returns read data through a fixed-latency pipeline.
module sram_access_ctrl #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic [AW-1:0] A_out,
    output logic          WEN_out,
    output logic          CEN_out,
    output logic [DW-1:0] D_out,
    input  logic [DW-1:0] Q_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] a_d;
    logic [DW-1:0] d_d;
    logic          cen_d;
    logic          wen_d;

    // Read-beat tracking: stage 0 aligns with CEN_out, stage 1 with Q_in.
    logic          issue_rd, issue_last;
    logic          s0_valid, s0_last;
    logic          s1_valid, s1_last;
    logic          pipe_empty;

    assign pipe_empty = !(s0_valid || s1_valid);
    assign busy       = (state_q != IDLE) || !pipe_empty;

    // Next-state and next SRAM command.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        a_d        = A_out;
        d_d        = D_out;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        issue_rd   = 1'b0;
        issue_last = 1'b0;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = pipe_empty;
                if (req_valid && pipe_empty) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = LW'(0);
                    state_d = req_write ? WR : RD;
                end
            end
            RD: begin
                cen_d    = 1'b0;
                a_d      = addr_q;
                addr_d   = AW'(addr_q + AW'(1));
                cnt_d    = LW'(cnt_q + LW'(1));
                issue_rd = 1'b1;
                if (cnt_q == len_q) begin
                    issue_last = 1'b1;
                    state_d    = DRAIN;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    cen_d  = 1'b0;
                    wen_d  = 1'b0;
                    a_d    = addr_q;
                    d_d    = wr_data;
                    addr_d = AW'(addr_q + AW'(1));
                    cnt_d  = LW'(cnt_q + LW'(1));
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, SRAM command registers and read return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            A_out    <= '0;
            D_out    <= '0;
            CEN_out  <= 1'b1;
            WEN_out  <= 1'b1;
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            A_out    <= a_d;
            D_out    <= d_d;
            CEN_out  <= cen_d;
            WEN_out  <= wen_d;
            s0_valid <= issue_rd;
            s0_last  <= issue_last;
            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            rd_valid <= s1_valid;
            rd_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                rd_data <= Q_in;
            end
        end
    end

endmodule
